// File: rtl/debounce_pkg.sv
// Shared helpers for the button debouncer: counter sizing used by every channel.
package debounce_pkg;

  // Bits needed to hold 0..n inclusive; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, tick-paced stability filter, edge pulses and optional auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_TICKS  = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button,
  output logic level,
  output logic pressed,
  output logic released,
  output logic repeat_hit
);

  localparam int CW = cnt_width(STABLE_TICKS);

  if (SYNC_STAGES < 2)   begin : g_bad_sync   $error("SYNC_STAGES must be >= 2");   end
  if (STABLE_TICKS < 1)  begin : g_bad_stable $error("STABLE_TICKS must be >= 1");  end
  if (REPEAT_DELAY > 0 && REPEAT_PERIOD < 1) begin : g_bad_period
    $error("REPEAT_PERIOD must be >= 1 when auto-repeat is enabled");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;
  logic                   flip;

  assign s    = sync_q[SYNC_STAGES-1];
  assign flip = tick && (s != level) && (cnt == CW'(STABLE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cnt      <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], button};
      pressed  <= flip && s;
      released <= flip && !s;
      // Any agreeing tick restarts the stability window, which is what rejects bounce.
      if (tick) begin
        if (s == level) begin
          cnt <= '0;
        end else if (flip) begin
          level <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  if (REPEAT_DELAY > 0) begin : g_rep
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = cnt_width(RMAX);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rnext;
    logic          rphase;
    logic          rhit;

    // rphase=0 waits out the initial delay, rphase=1 paces the periodic repeats.
    assign rnext = rcnt + 1'b1;
    assign rhit  = tick && level && !flip &&
                   (rphase ? (rnext == RW'(REPEAT_PERIOD)) : (rnext == RW'(REPEAT_DELAY)));

    always_ff @(posedge clk) begin
      if (rst) begin
        rcnt       <= '0;
        rphase     <= 1'b0;
        repeat_hit <= 1'b0;
      end else begin
        repeat_hit <= rhit;
        if (!level || flip) begin
          rcnt   <= '0;
          rphase <= 1'b0;
        end else if (rhit) begin
          rcnt   <= '0;
          rphase <= 1'b1;
        end else if (tick) begin
          rcnt <= rnext;
        end
      end
    end
  end else begin : g_norep
    assign repeat_hit = 1'b0;
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// Multi-channel debouncer: CHANNELS independent debounce_channel instances sharing clk, rst and tick.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_TICKS  = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CHANNELS-1:0] buttons,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] repeat_hit
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .button    (buttons[i]),
      .level     (level[i]),
      .pressed   (pressed[i]),
      .released  (released[i]),
      .repeat_hit(repeat_hit[i])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench: two debouncer builds (no repeat / repeat 8,3) on shared inputs, checked against a behavioural model.
module tb_multi_button_debouncer;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int ST = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 0;
  logic rst = 1;
  logic tick = 1;
  logic [CH-1:0] buttons = '0;
  logic [CH-1:0] lv0, pr0, rl0, rp0;
  logic [CH-1:0] lvr, prr, rlr, rpr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit tick_div = 0;

  always #5 clk = ~clk;

  multi_button_debouncer #(.CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_TICKS(ST),
                           .REPEAT_DELAY(0), .REPEAT_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .buttons(buttons),
    .level(lv0), .pressed(pr0), .released(rl0), .repeat_hit(rp0));

  multi_button_debouncer #(.CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_TICKS(ST),
                           .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_r (
    .clk(clk), .rst(rst), .tick(tick), .buttons(buttons),
    .level(lvr), .pressed(prr), .released(rlr), .repeat_hit(rpr));

  // Behavioural model: raw input delayed SS edges, then "ST consecutive disagreeing ticks flips".
  int m_sync[CH][SS];
  int m_level[CH], m_run[CH], m_held[CH];
  bit e_p[CH], e_r[CH], e_rep[CH];

  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < CH; c++) begin
      e_p[c] = 0; e_r[c] = 0; e_rep[c] = 0;
      if (rst) begin
        for (int k = 0; k < SS; k++) m_sync[c][k] = 0;
        m_level[c] = 0; m_run[c] = 0; m_held[c] = 0;
      end else begin
        int s;
        bit flip;
        s = m_sync[c][SS-1];
        for (int k = SS-1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
        m_sync[c][0] = int'(buttons[c]);
        flip = 0;
        if (tick) begin
          if (s == m_level[c]) m_run[c] = 0;
          else begin
            m_run[c]++;
            if (m_run[c] == ST) begin
              m_level[c] = s; m_run[c] = 0; flip = 1;
              if (s != 0) e_p[c] = 1; else e_r[c] = 1;
            end
          end
        end
        // Ticks held since the press; repeats at RD, RD+RP, RD+2RP, ...
        if (m_level[c] == 0 || flip) m_held[c] = 0;
        else if (tick) begin
          m_held[c]++;
          if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0)) e_rep[c] = 1;
        end
      end
    end
  end

  always @(negedge clk) tick = tick_div ? (cyc % 10 == 0) : 1'b1;

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare of both builds against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic [CH-1:0] el, ep, er, erp;
      for (int c = 0; c < CH; c++) begin
        el[c] = m_level[c] != 0; ep[c] = e_p[c]; er[c] = e_r[c]; erp[c] = e_rep[c];
      end
      check("level",      lv0, el);
      check("pressed",    pr0, ep);
      check("released",   rl0, er);
      check("repeat_off", rp0, '0);
      check("level_r",    lvr, el);
      check("pressed_r",  prr, ep);
      check("released_r", rlr, er);
      check("repeat_r",   rpr, erp);
    end
  end

  task automatic wait_level(input int ch, input logic val, input int bound, output int at);
    at = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (lv0[ch] === val) begin at = cyc; break; end
    end
    if (at < 0) begin
      tests++; fails++;
      $display("FAIL wait_level ch%0d: timeout after %0d cycles, level %b want %b", ch, bound, lv0[ch], val);
    end
  endtask

  initial begin
    int t0, at, pc, nrep;
    int reps[$];
    repeat (3) @(negedge clk);
    check("reset_level", lv0, 4'b0000);
    rst = 0;
    repeat (2) @(negedge clk);

    // 1: clean press on ch0
    buttons[0] = 1; t0 = cyc;
    wait_level(0, 1, 20, at);
    check_int("t1_latency", at - t0, 6);
    check("t1_pressed", pr0, 4'b0001);
    @(negedge clk);
    check("t1_pulse_len", pr0, 4'b0000);

    // 2: bounce on ch1, then steady high
    for (int b = 0; b < 5; b++) begin
      buttons[1] = 1; repeat (3) @(negedge clk);
      buttons[1] = 0; @(negedge clk);
    end
    check("t2_no_flip", lv0 & 4'b0010, 4'b0000);
    buttons[1] = 1; t0 = cyc;
    wait_level(1, 1, 20, at);
    check_int("t2_latency", at - t0, 6);

    // 3: release ch0
    repeat (3) @(negedge clk);
    buttons[0] = 0; t0 = cyc;
    wait_level(0, 0, 20, at);
    check_int("t3_latency", at - t0, 6);
    check("t3_released", rl0, 4'b0001);

    // 4: slow tick, press ch2; level may only move on a tick edge
    tick_div = 1;
    buttons[2] = 1;
    wait_level(2, 1, 200, at);
    check_int("t4_on_tick_edge", at % 10, 1);
    tick_div = 0;
    buttons[2] = 0;
    wait_level(2, 0, 20, at);

    // 5: hold ch3 on the repeat build
    buttons[3] = 1;
    wait_level(3, 1, 20, pc);
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (rpr[3]) reps.push_back(cyc - pc);
    end
    check_int("t5_rep_count", reps.size(), 3);
    if (reps.size() == 3) begin
      check_int("t5_rep0", reps[0], 8);
      check_int("t5_rep1", reps[1], 11);
      check_int("t5_rep2", reps[2], 14);
    end
    @(negedge clk);
    buttons[3] = 0;
    wait_level(3, 0, 20, at);
    check("t5_released", rlr & 4'b1000, 4'b1000);
    nrep = 0;
    repeat (20) begin @(negedge clk); if (rpr[3]) nrep++; end
    check_int("t5_no_more_rep", nrep, 0);

    // 6: all pressed, reset mid-count
    buttons = '0;
    repeat (10) @(negedge clk);
    buttons = 4'hF;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("t6_rst_level", lv0, 4'b0000);
    check("t6_rst_pressed", pr0, 4'b0000);
    rst = 0; t0 = cyc;
    wait_level(0, 1, 20, at);
    check_int("t6_latency", at - t0, 6);
    check("t6_all_level", lv0, 4'hF);
    check("t6_all_pressed", pr0, 4'hF);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
